// File: rtl/key_start_ctrl.sv
// rtl/key_start_ctrl.sv - key debounce and m1/m2 start/track control (optional timeout: START_TIMEOUT_EN)
module key_start_ctrl #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter int         TIMEOUT_CYCLES  = 1000000,
   parameter logic [3:0] ADDR_LSB        = 4'h2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [3:0]  keysn,
   input  logic [17:0] sws,
   input  logic        m1_done,
   input  logic        m2_done,
   output logic        m1_start,
   output logic        m2_start,
   output logic        m1_mode,
   output logic        m2_mode,
   output logic [15:0] m1_addr,
   output logic [15:0] m2_addr,
   output logic [1:0]  busy,
   output logic [1:0]  err
);

   localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    r_db;
   logic [3:0]    r_db_d;
   logic [CW-1:0] r_cnt [4];
   logic [3:0]    w_press;

   state_t        r_state     [2];
   state_t        w_state_nxt [2];
   logic [1:0]    w_trig;
   logic [1:0]    w_done;
   logic [1:0]    w_tmo;
   logic          r_m1_mode;
   logic          r_m2_mode;
   logic [15:0]   r_m1_addr;
   logic [15:0]   r_m2_addr;

   // Keys are active-low, so a press is the debounced level falling.
   assign w_press = r_db_d & ~r_db;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
         r_db    <= 4'hF;
         r_db_d  <= 4'hF;
         for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
      end else begin
         r_sync1 <= keysn;
         r_sync2 <= r_sync1;
         r_db_d  <= r_db;
         for (int k = 0; k < 4; k++) begin
            if (r_sync2[k] == r_db[k]) begin
               r_cnt[k] <= '0;
            end else if (r_cnt[k] >= C_DB_LAST) begin
               r_db[k]  <= r_sync2[k];
               r_cnt[k] <= '0;
            end else begin
               r_cnt[k] <= r_cnt[k] + CW'(1);
            end
         end
      end
   end

   assign w_trig[0] = (w_press[0] | w_press[2]) & sws[0];
   assign w_trig[1] = (w_press[1] | w_press[2]) & sws[2];
   assign w_done    = {m2_done, m1_done};

   always_comb begin
      for (int x = 0; x < 2; x++) begin
         w_state_nxt[x] = r_state[x];
         case (r_state[x])
            ST_IDLE:  if (w_trig[x]) w_state_nxt[x] = ST_START;
            ST_START: w_state_nxt[x] = ST_WAIT;
            ST_WAIT:  if (w_done[x] || w_tmo[x]) w_state_nxt[x] = ST_IDLE;
            default:  w_state_nxt[x] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state[0] <= ST_IDLE;
         r_state[1] <= ST_IDLE;
         r_m1_mode  <= 1'b0;
         r_m2_mode  <= 1'b0;
         r_m1_addr  <= '0;
         r_m2_addr  <= '0;
      end else begin
         r_state[0] <= w_state_nxt[0];
         r_state[1] <= w_state_nxt[1];
         if (r_state[0] == ST_IDLE && w_trig[0]) begin
            r_m1_mode <= sws[1];
            r_m1_addr <= {sws[15:4], ADDR_LSB};
         end
         if (r_state[1] == ST_IDLE && w_trig[1]) begin
            r_m2_mode <= sws[3];
            r_m2_addr <= {sws[15:4], ADDR_LSB};
         end
      end
   end

`ifdef START_TIMEOUT_EN
   localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] r_tcnt [2];
   logic [1:0]    r_err;

   // A done arriving in the expiry cycle wins over the timeout.
   always_comb begin
      for (int x = 0; x < 2; x++) begin
         w_tmo[x] = (r_state[x] == ST_WAIT) && !w_done[x] && (r_tcnt[x] >= C_TO_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_tcnt[0] <= '0;
         r_tcnt[1] <= '0;
         r_err     <= 2'b00;
      end else begin
         for (int x = 0; x < 2; x++) begin
            if (r_state[x] != ST_WAIT)    r_tcnt[x] <= '0;
            else if (r_tcnt[x] < C_TO_LAST) r_tcnt[x] <= r_tcnt[x] + TW'(1);
         end
         r_err <= w_tmo | (r_err & ~{2{w_press[3]}});
      end
   end

   assign err = r_err;
`else
   assign w_tmo = 2'b00;
   assign err   = 2'b00;
`endif

   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, sws[17:16], w_press[3], TIMEOUT_CYCLES[0]};

   assign m1_start = (r_state[0] == ST_START);
   assign m2_start = (r_state[1] == ST_START);
   assign busy     = {r_state[1] != ST_IDLE, r_state[0] != ST_IDLE};
   assign m1_mode  = r_m1_mode;
   assign m2_mode  = r_m2_mode;
   assign m1_addr  = r_m1_addr;
   assign m2_addr  = r_m2_addr;

endmodule
